word_scheduler: RTL and testbench
=================================

# word_scheduler

Sequencer sitting between the debounced user controls and the `sendword` serializer. It queues manual word requests in a small FIFO, generates periodic auto-mode words from the heartbeat tick, and arbitrates both onto the single `sendword` enable/status handshake, one transaction at a time. It replaces the direct `write_deb && status` gating at top level, so no request is lost or issued while the serializer is busy.

## Interface

Parameters:
- `FIFO_DEPTH`, 4: manual request queue depth; power of two, at least 2.
- `ACK_TIMEOUT`, 16: cycles to wait for `tx_ready` to fall after `tx_enable`; at least 2.

Ports:
- `sysclk` in 1: system clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `man_req` in 1: single-cycle pulse from the debounced write button.
- `man_word` in 2: word to queue; sampled when `man_req`=1.
- `auto_en` in 1: level; enables auto mode.
- `tick` in 1: single-cycle heartbeat pulse from `clockdiv`.
- `tx_ready` in 1: `sendword` status; 1 = idle, 0 = shifting.
- `tx_enable` out 1: one-cycle start pulse to `sendword`.
- `tx_word` out 2: word presented to `sendword`; stable from `tx_enable` until the transaction ends.
- `busy` out 1: 1 whenever the state is not IDLE.
- `fifo_count` out clog2(FIFO_DEPTH)+1: number of queued manual words.
- `overflow` out 1: sticky; set when a request is dropped because the FIFO is full.
- `timeout_err` out 1: sticky; set on an ack timeout.

## Operation

- Reset values: `tx_enable`=0, `tx_word`=00, `busy`=0, `fifo_count`=0, `overflow`=0, `timeout_err`=0. The FIFO is emptied, `auto_pending` is cleared, the auto counter is set to 00, and the state is IDLE.
- The sticky flags are cleared only by reset.
- **FIFO push:** `man_req`=1 and not full pushes `man_word`.
  - If full, the request is dropped and `overflow` is set.
  - A push and a pop in the same cycle are legal, and the count is unchanged.
- **Auto:** `tick`=1 with `auto_en`=1 sets `auto_pending`.
  - A tick while `auto_pending` is already set is merged, not counted.
  - Deasserting `auto_en` clears `auto_pending`.
  - The auto word is the counter value. The counter increments after each auto transaction, wrapping from 11 to 00.
- **Arbitration:** manual has strict priority. An auto send happens only when the FIFO is empty.

State machine:
- **IDLE:** if `tx_ready`=1 and (FIFO non-empty or `auto_pending`), go to START. On the same edge, either:
  - pop the FIFO head into `tx_word`, or
  - load the auto counter into `tx_word` and clear `auto_pending`.
- **START:** `tx_enable`=1 for exactly this cycle. Go to WAIT_ACK and clear the timeout counter.
- **WAIT_ACK:** on `tx_ready`=0, go to WAIT_DONE. Otherwise increment the counter. When the counter reaches ACK_TIMEOUT-1, set `timeout_err` and go to IDLE.
  - The word is not re-sent.
  - An auto word still advances the counter.
- **WAIT_DONE:** on `tx_ready`=1, go to IDLE. If the word was an auto word, increment the auto counter on this edge.

## Timing

- Manual request in cycle n, with the FIFO empty, the block idle and `tx_ready`=1:
  - pushed at the end of n;
  - popped at the end of n+1;
  - `tx_enable` high in cycle n+2.
- Tick in cycle n, in the same conditions: `tx_enable` high in cycle n+2.
- `tx_enable` is never high in two consecutive cycles.
- The minimum gap between `tx_enable` pulses is 4 cycles (START, WAIT_ACK, WAIT_DONE, IDLE).
- `fifo_count` updates on the edge after a push or pop.
- `overflow` is set on the edge that drops the request.
- Reset asserted mid-transaction forces all outputs to their reset values immediately (asynchronous). Any in-flight `sendword` shift is not aborted by this block.
- A `man_req` in the same cycle as an IDLE-to-START pop of the last entry is pushed normally and served next.

## Configuration

- `WORD_SCHED_AUTO_EN` defined: auto mode is present as described.
- Not defined:
  - `auto_en` and `tick` are ignored;
  - `auto_pending` and the auto counter are not built;
  - only FIFO entries are scheduled;
  - all other behaviour is identical.

## Test plan

- **Single manual request:** `man_req` with `man_word`=10, `tx_ready` idle.
  - Required: `tx_enable` exactly one cycle, 2 cycles later, with `tx_word`=10.
  - Model `tx_ready` low for 8 cycles; `busy` drops one cycle after `tx_ready` returns high.
- **Overflow:** 5 back-to-back `man_req` (00,01,10,11,01) while `tx_ready` is held low.
  - Required: `fifo_count` reaches 4, then `overflow`=1.
  - On release, words are sent in order 00,01,10,11; the fifth is absent.
- **Auto sequence:** `auto_en`=1 and 5 ticks spaced 50 cycles apart.
  - Required: `tx_word` sequence 00,01,10,11,00.
- **Priority and tick merging:** a tick and a `man_req` (11) in the same cycle, FIFO empty.
  - Required: manual 11 is sent first, then the auto word.
  - A second tick during the manual transaction still yields only one auto send.
- **Ack timeout:** `tx_ready` stuck at 1 after `tx_enable`.
  - Required: `timeout_err`=1 exactly ACK_TIMEOUT cycles after the WAIT_ACK entry.
  - Return to IDLE; the next queued word is then issued.
- **Reset mid-transaction:** `rst_n` pulled low during WAIT_DONE with 2 words queued.
  - Required: all outputs are at reset values within the same cycle, `fifo_count`=0, and no `tx_enable` follows after release.

Source files
------------

// File: rtl/word_scheduler_if.sv
// Enable/status handshake between word_scheduler and the sendword serializer.
interface word_scheduler_if;
   logic       tx_enable;
   logic [1:0] tx_word;
   logic       tx_ready;

   modport master (
      output tx_enable,
      output tx_word,
      input  tx_ready
   );

   modport slave (
      input  tx_enable,
      input  tx_word,
      output tx_ready
   );
endinterface

// File: rtl/word_scheduler.sv
// Queues manual words, adds periodic auto words, issues one sendword transaction at a time.
// Auto mode is built only when WORD_SCHED_AUTO_EN is defined.
module word_scheduler #(
   parameter int FIFO_DEPTH  = 4,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic                        sysclk,
   input  logic                        rst_n,
   input  logic                        man_req,
   input  logic [1:0]                  man_word,
   input  logic                        auto_en,
   input  logic                        tick,
   word_scheduler_if.master            tx,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overflow,
   output logic                        timeout_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(ACK_TIMEOUT);
   localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TIMEOUT - 1);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT_ACK,
      WAIT_DONE
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [1:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;
   logic          empty;
   logic          full;
   logic          push;
   logic          drop;
   logic          pop;

   logic [TW-1:0] ack_cnt;
   logic          ack_clr;
   logic          ack_inc;
   logic          set_timeout;

   logic [1:0]    word_q;

`ifdef WORD_SCHED_AUTO_EN
   logic          auto_pending;
   logic [1:0]    auto_cnt;
   logic          load_auto;
   logic          is_auto;
   logic          auto_done;
`else
   logic          unused_auto;
   assign unused_auto = auto_en ^ tick;
`endif

   assign empty = (count == '0);
   assign full  = (count == FULL_CNT);
   assign push  = man_req && !full;
   assign drop  = man_req && full;

   assign tx.tx_enable = (state == START);
   assign tx.tx_word   = word_q;
   assign busy         = (state != IDLE);
   assign fifo_count   = count;

   always_comb begin
      state_nxt   = state;
      pop         = 1'b0;
      ack_clr     = 1'b0;
      ack_inc     = 1'b0;
      set_timeout = 1'b0;
`ifdef WORD_SCHED_AUTO_EN
      load_auto   = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            if (tx.tx_ready && !empty) begin
               pop       = 1'b1;
               state_nxt = START;
            end
`ifdef WORD_SCHED_AUTO_EN
            else if (tx.tx_ready && auto_pending) begin
               load_auto = 1'b1;
               state_nxt = START;
            end
`endif
         end
         START: begin
            ack_clr   = 1'b1;
            state_nxt = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (!tx.tx_ready) begin
               state_nxt = WAIT_DONE;
            end else if (ack_cnt == ACK_LAST) begin
               // give up on this word; it is not re-sent
               set_timeout = 1'b1;
               state_nxt   = IDLE;
            end else begin
               ack_inc = 1'b1;
            end
         end
         WAIT_DONE: begin
            if (tx.tx_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         ack_cnt <= '0;
      end else if (ack_clr) begin
         ack_cnt <= '0;
      end else if (ack_inc) begin
         ack_cnt <= ack_cnt + TW'(1);
      end
   end

   always_ff @(posedge sysclk) begin
      if (push) begin
         mem[wr_ptr] <= man_word;
      end
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({push, pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         overflow    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (drop) begin
            overflow <= 1'b1;
         end
         if (set_timeout) begin
            timeout_err <= 1'b1;
         end
      end
   end

`ifdef WORD_SCHED_AUTO_EN
   assign auto_done = is_auto &&
                      (set_timeout ||
                       (state == WAIT_DONE && tx.tx_ready));

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         word_q  <= 2'b00;
         is_auto <= 1'b0;
      end else if (pop) begin
         word_q  <= mem[rd_ptr];
         is_auto <= 1'b0;
      end else if (load_auto) begin
         word_q  <= auto_cnt;
         is_auto <= 1'b1;
      end
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         auto_pending <= 1'b0;
         auto_cnt     <= 2'b00;
      end else begin
         // a tick while one is already pending merges into it
         if (!auto_en) begin
            auto_pending <= 1'b0;
         end else if (tick) begin
            auto_pending <= 1'b1;
         end else if (load_auto) begin
            auto_pending <= 1'b0;
         end
         if (auto_done) begin
            auto_cnt <= auto_cnt + 2'd1;
         end
      end
   end
`else
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         word_q <= 2'b00;
      end else if (pop) begin
         word_q <= mem[rd_ptr];
      end
   end
`endif

endmodule

// File: tb/tb_word_scheduler.sv
// Directed bench for word_scheduler; sendword status is driven by the test tasks.
module tb_word_scheduler;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       man_req = 1'b0;
   logic [1:0] man_word = 2'b00;
   logic       auto_en = 1'b0;
   logic       tick = 1'b0;
   logic       busy;
   logic [2:0] fifo_count;
   logic       overflow;
   logic       timeout_err;

   int checks = 0;
   int failures = 0;

   word_scheduler_if sif();

   word_scheduler dut (
      .sysclk      (clk),
      .rst_n       (rst_n),
      .man_req     (man_req),
      .man_word    (man_word),
      .auto_en     (auto_en),
      .tick        (tick),
      .tx          (sif),
      .busy        (busy),
      .fifo_count  (fifo_count),
      .overflow    (overflow),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic apply_reset;
      rst_n = 1'b0;
      man_req = 1'b0;
      tick = 1'b0;
      auto_en = 1'b0;
      sif.tx_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_enable(output bit ok, output logic [1:0] w);
      ok = 1'b0;
      w = 2'b00;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (sif.tx_enable === 1'b1) begin
            ok = 1'b1;
            w = sif.tx_word;
         end
      end
   endtask

   task automatic ack(input int n);
      @(negedge clk);
      sif.tx_ready = 1'b0;
      repeat (n) @(negedge clk);
      sif.tx_ready = 1'b1;
   endtask

   task automatic count_enables(input int n, output int seen);
      seen = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (sif.tx_enable === 1'b1) seen++;
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst_n = 1'b0;
      sif.tx_ready = 1'b1;
      #1;
      checks++;
      if ({sif.tx_enable, sif.tx_word, busy} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_tx got en=%b word=%b busy=%b exp 0/00/0",
                  sif.tx_enable, sif.tx_word, busy);
      end
      checks++;
      if ({fifo_count, overflow, timeout_err} !== 5'b00000) begin
         failures++;
         $display("FAIL reset_flags got cnt=%0d ovf=%b to=%b exp 0/0/0",
                  fifo_count, overflow, timeout_err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || sif.tx_enable !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle got busy=%b en=%b exp 0/0",
                  busy, sif.tx_enable);
      end
   endtask

   task automatic test_manual;
      apply_reset();
      @(negedge clk);
      man_req = 1'b1;
      man_word = 2'b10;
      @(negedge clk);
      man_req = 1'b0;
      checks++;
      if (fifo_count !== 3'd1 || sif.tx_enable !== 1'b0) begin
         failures++;
         $display("FAIL man_push got cnt=%0d en=%b exp 1/0",
                  fifo_count, sif.tx_enable);
      end
      @(negedge clk);
      checks++;
      if (sif.tx_enable !== 1'b1 || sif.tx_word !== 2'b10 || busy !== 1'b1) begin
         failures++;
         $display("FAIL man_start got en=%b word=%b busy=%b exp 1/10/1",
                  sif.tx_enable, sif.tx_word, busy);
      end
      checks++;
      if (fifo_count !== 3'd0) begin
         failures++;
         $display("FAIL man_pop got cnt=%0d exp 0", fifo_count);
      end
      @(negedge clk);
      sif.tx_ready = 1'b0;
      checks++;
      if (sif.tx_enable !== 1'b0) begin
         failures++;
         $display("FAIL man_pulse_width got en=%b exp 0", sif.tx_enable);
      end
      repeat (8) @(negedge clk);
      sif.tx_ready = 1'b1;
      checks++;
      if (busy !== 1'b1 || sif.tx_word !== 2'b10) begin
         failures++;
         $display("FAIL man_hold got busy=%b word=%b exp 1/10",
                  busy, sif.tx_word);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL man_done got busy=%b exp 0", busy);
      end
   endtask

   task automatic test_overflow;
      logic [1:0] wv [5];
      bit ok;
      logic [1:0] w;
      int seen;
      wv = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01};
      apply_reset();
      sif.tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i == 4) begin
            checks++;
            if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
               failures++;
               $display("FAIL ovf_fill got cnt=%0d ovf=%b exp 4/0",
                        fifo_count, overflow);
            end
         end
         man_req = 1'b1;
         man_word = wv[i];
      end
      @(negedge clk);
      man_req = 1'b0;
      checks++;
      if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
         failures++;
         $display("FAIL ovf_drop got cnt=%0d ovf=%b exp 4/1",
                  fifo_count, overflow);
      end
      sif.tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_enable(ok, w);
         checks++;
         if (!ok || w !== wv[i]) begin
            failures++;
            $display("FAIL ovf_order[%0d] got ok=%b word=%b exp 1/%b",
                     i, ok, w, wv[i]);
         end
         ack(3);
      end
      count_enables(20, seen);
      checks++;
      if (seen != 0 || fifo_count !== 3'd0 || overflow !== 1'b1) begin
         failures++;
         $display("FAIL ovf_tail got extra=%0d cnt=%0d ovf=%b exp 0/0/1",
                  seen, fifo_count, overflow);
      end
   endtask

   task automatic test_timeout;
      bit ok;
      logic [1:0] w;
      apply_reset();
      @(negedge clk);
      man_req = 1'b1;
      man_word = 2'b01;
      @(negedge clk);
      man_word = 2'b10;
      @(negedge clk);
      man_req = 1'b0;
      checks++;
      if (sif.tx_enable !== 1'b1 || sif.tx_word !== 2'b01 || fifo_count !== 3'd1) begin
         failures++;
         $display("FAIL to_start got en=%b word=%b cnt=%0d exp 1/01/1",
                  sif.tx_enable, sif.tx_word, fifo_count);
      end
      repeat (16) @(negedge clk);
      checks++;
      if (timeout_err !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL to_early got to=%b busy=%b exp 0/1",
                  timeout_err, busy);
      end
      @(negedge clk);
      checks++;
      if (timeout_err !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL to_fire got to=%b busy=%b exp 1/0",
                  timeout_err, busy);
      end
      @(negedge clk);
      checks++;
      if (sif.tx_enable !== 1'b1 || sif.tx_word !== 2'b10) begin
         failures++;
         $display("FAIL to_next got en=%b word=%b exp 1/10",
                  sif.tx_enable, sif.tx_word);
      end
      ack(3);
      wait_enable(ok, w);
      checks++;
      if (ok || timeout_err !== 1'b1) begin
         failures++;
         $display("FAIL to_after got extra=%b to=%b exp 0/1", ok, timeout_err);
      end
   endtask

   task automatic test_priority;
      bit ok;
      logic [1:0] w;
      int seen;
      apply_reset();
      auto_en = 1'b1;
      @(negedge clk);
      tick = 1'b1;
      man_req = 1'b1;
      man_word = 2'b11;
      @(negedge clk);
      tick = 1'b0;
      man_req = 1'b0;
      @(negedge clk);
      checks++;
      if (sif.tx_enable !== 1'b1 || sif.tx_word !== 2'b11) begin
         failures++;
         $display("FAIL prio_manual got en=%b word=%b exp 1/11",
                  sif.tx_enable, sif.tx_word);
      end
      @(negedge clk);
      sif.tx_ready = 1'b0;
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      repeat (3) @(negedge clk);
      sif.tx_ready = 1'b1;
`ifdef WORD_SCHED_AUTO_EN
      wait_enable(ok, w);
      checks++;
      if (!ok || w !== 2'b00) begin
         failures++;
         $display("FAIL prio_auto got ok=%b word=%b exp 1/00", ok, w);
      end
      ack(3);
`endif
      count_enables(30, seen);
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL prio_merge got extra=%0d exp 0", seen);
      end
      auto_en = 1'b0;
   endtask

`ifdef WORD_SCHED_AUTO_EN
   task automatic test_auto;
      logic [1:0] ev [5];
      int seen;
      ev = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
      apply_reset();
      auto_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
         checks++;
         if (sif.tx_enable !== 1'b0) begin
            failures++;
            $display("FAIL auto_early[%0d] got en=%b exp 0", i, sif.tx_enable);
         end
         @(negedge clk);
         checks++;
         if (sif.tx_enable !== 1'b1 || sif.tx_word !== ev[i]) begin
            failures++;
            $display("FAIL auto_word[%0d] got en=%b word=%b exp 1/%b",
                     i, sif.tx_enable, sif.tx_word, ev[i]);
         end
         ack(4);
         repeat (42) @(negedge clk);
      end
      sif.tx_ready = 1'b0;
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      auto_en = 1'b0;
      @(negedge clk);
      sif.tx_ready = 1'b1;
      count_enables(20, seen);
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL auto_cancel got sends=%0d exp 0", seen);
      end
   endtask
`else
   task automatic test_auto_ignored;
      int seen;
      apply_reset();
      auto_en = 1'b1;
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      count_enables(20, seen);
      checks++;
      if (seen != 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL auto_off got sends=%0d busy=%b exp 0/0", seen, busy);
      end
      auto_en = 1'b0;
   endtask
`endif

   task automatic test_reset_mid;
      int seen;
      apply_reset();
      @(negedge clk);
      man_req = 1'b1;
      man_word = 2'b11;
      @(negedge clk);
      man_req = 1'b0;
      @(negedge clk);
      checks++;
      if (sif.tx_enable !== 1'b1 || sif.tx_word !== 2'b11) begin
         failures++;
         $display("FAIL rmid_start got en=%b word=%b exp 1/11",
                  sif.tx_enable, sif.tx_word);
      end
      @(negedge clk);
      sif.tx_ready = 1'b0;
      man_req = 1'b1;
      man_word = 2'b01;
      @(negedge clk);
      man_word = 2'b10;
      @(negedge clk);
      man_req = 1'b0;
      checks++;
      if (fifo_count !== 3'd2 || busy !== 1'b1) begin
         failures++;
         $display("FAIL rmid_queued got cnt=%0d busy=%b exp 2/1",
                  fifo_count, busy);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({sif.tx_enable, sif.tx_word, busy, fifo_count} !== 7'b0) begin
         failures++;
         $display("FAIL rmid_async got en=%b word=%b busy=%b cnt=%0d exp 0/00/0/0",
                  sif.tx_enable, sif.tx_word, busy, fifo_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      sif.tx_ready = 1'b1;
      count_enables(30, seen);
      checks++;
      if (seen != 0 || fifo_count !== 3'd0) begin
         failures++;
         $display("FAIL rmid_quiet got sends=%0d cnt=%0d exp 0/0",
                  seen, fifo_count);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      sif.tx_ready = 1'b1;
      test_reset();
      test_manual();
      test_overflow();
      test_timeout();
      test_priority();
`ifdef WORD_SCHED_AUTO_EN
      test_auto();
`else
      test_auto_ignored();
`endif
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
